// File: rtl/cpu_pkg.sv
// cpu_pkg: types and widths shared by the CPU and its program loader.
// Rev 1.0
`default_nettype none
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/load_sum.sv
// load_sum: clear/accumulate modular adder for the image checksum.
// Rev 1.0
`default_nettype none
module load_sum
  import cpu_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   sum <= '0;
    else if (clr) sum <= '0;
    else if (acc) sum <= sum + din;
  end

endmodule
`default_nettype wire

// File: rtl/code_loader.sv
// code_loader: length-prefixed image loader for code memory; holds the CPU in reset until done.
// Optional trailing checksum word enabled by CODE_LOADER_CHECKSUM_EN. Rev 1.0
`default_nettype none
module code_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = WORD_W,
  parameter int DEPTH  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  localparam logic [DATA_W:0] DEPTH_L = (DATA_W+1)'(DEPTH);
`ifdef CODE_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = ST_CHK;
`else
  localparam loader_state_t AFTER_DATA = ST_RUN;
`endif

  loader_state_t     state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx, len, len_nx, addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              we_nx, accept;

  assign accept   = in_valid && in_ready;
  assign in_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
  assign busy     = in_ready;

`ifdef CODE_LOADER_CHECKSUM_EN
  logic              sum_clr, sum_acc;
  logic [DATA_W-1:0] sum;

  load_sum #(.W(DATA_W)) u_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (sum_clr),
    .acc   (sum_acc),
    .din   (in_data),
    .sum   (sum)
  );
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len;
    we_nx    = 1'b0;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
`ifdef CODE_LOADER_CHECKSUM_EN
    sum_clr  = 1'b0;
    sum_acc  = 1'b0;
`endif
    if (start) begin
      // Restart beats any same-edge handshake; the offered word is dropped.
      state_nx = ST_LEN;
      cnt_nx   = '0;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_clr  = 1'b1;
`endif
    end else if (accept) begin
      case (state)
        ST_LEN: begin
          if (in_data == '0) begin
            state_nx = AFTER_DATA;
          end else if ({1'b0, in_data} > DEPTH_L) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_DATA;
            len_nx   = ADDR_W'(in_data);
            cnt_nx   = '0;
          end
        end
        ST_DATA: begin
          we_nx    = 1'b1;
          addr_nx  = cnt;
          wdata_nx = in_data;
          cnt_nx   = cnt + 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_acc  = 1'b1;
`endif
          if (cnt == len - 1'b1) state_nx = AFTER_DATA;
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        ST_CHK: state_nx = (in_data == sum) ? ST_RUN : ST_ERR;
`endif
        default: ;
      endcase
    end
  end

  // cpu_run feeds the CPU reset, so it comes straight from a flop, not a state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      len       <= len_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      cpu_run   <= (state_nx == ST_RUN);
      err       <= (state_nx == ST_ERR);
    end
  end

endmodule
`default_nettype wire
